// File: rtl/greenflow_gate_mc.sv
// Multi-channel greenflow safety gate: per-channel thermal/stale status, shared
// grid budget allocated by channel priority, and upward ramp limiting on outputs.
module greenflow_gate_mc #(
  parameter int CH            = 4,
  parameter int W             = 16,
  parameter int RAMP_STEP     = 50,
  parameter int DERATE_MARGIN = 10,
  parameter int TEMP_HYST     = 5,
  parameter int STALE_CYCLES  = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH*W-1:0]           req_kw,
  input  logic [CH-1:0]             req_valid,
  input  logic [CH*W-1:0]           batt_temp,
  input  logic [W-1:0]              grid_limit,
  input  logic [W-1:0]              temp_limit,
  input  logic                      clear_fault,
  output logic [CH*W-1:0]           power_out,
  output logic [CH*2-1:0]           status_code,
  output logic [W+$clog2(CH)-1:0]   total_out
);

  localparam int TW = W + $clog2(CH);
  localparam int CW = $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_DERATE = 2'b01,
    ST_FAULT  = 2'b10,
    ST_STALE  = 2'b11
  } status_e;

  status_e        state_q [CH];
  status_e        state_d [CH];
  logic [CW-1:0]  stale_q [CH];
  logic [CW-1:0]  stale_d [CH];
  logic [W-1:0]   req_q   [CH];
  logic [W-1:0]   pow_q   [CH];
  logic [W-1:0]   pow_d   [CH];
  logic [W-1:0]   grant   [CH];
  logic [W-1:0]   grid_q;
  logic [TW-1:0]  total_d;

  // Temperature sums use W+1 bits so a limit near full scale cannot wrap.
  always_comb begin : status_next
    logic [W:0] temp_ext;
    logic [W:0] limit_ext;
    logic       over_temp;
    logic       cooled;
    logic       warm;
    temp_ext  = '0;
    limit_ext = {1'b0, temp_limit};
    over_temp = 1'b0;
    cooled    = 1'b0;
    warm      = 1'b0;
    for (int i = 0; i < CH; i++) begin
      temp_ext  = {1'b0, batt_temp[i*W +: W]};
      over_temp = temp_ext >= limit_ext;
      cooled    = (temp_ext + (W+1)'(TEMP_HYST)) < limit_ext;
      warm      = (temp_ext + (W+1)'(DERATE_MARGIN)) >= limit_ext;

      stale_d[i] = stale_q[i];
      if (req_valid[i])
        stale_d[i] = '0;
      else if (stale_q[i] != STALE_MAX)
        stale_d[i] = stale_q[i] + CW'(1);

      state_d[i] = ST_OK;
      if (over_temp)
        state_d[i] = ST_FAULT;
      else if (state_q[i] == ST_FAULT && !(clear_fault && cooled))
        state_d[i] = ST_FAULT;
      else if (!req_valid[i] && stale_d[i] == STALE_MAX)
        state_d[i] = ST_STALE;
      else if (warm)
        state_d[i] = ST_DERATE;
    end
  end

  always_ff @(posedge clk) begin : status_reg
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        state_q[i] <= ST_STALE;
        stale_q[i] <= STALE_MAX;
      end else begin
        state_q[i] <= state_d[i];
        stale_q[i] <= stale_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin : stage1_reg
    if (rst) begin
      grid_q <= '0;
      for (int i = 0; i < CH; i++) req_q[i] <= '0;
    end else begin
      grid_q <= grid_limit;
      for (int i = 0; i < CH; i++)
        if (req_valid[i]) req_q[i] <= req_kw[i*W +: W];
    end
  end

  // Lower channel index takes budget first; what is left flows down the list.
  always_comb begin : grant_alloc
    logic [W-1:0] remaining;
    logic [W-1:0] target;
    remaining = grid_q;
    target    = '0;
    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        ST_OK:     target = req_q[i];
        ST_DERATE: target = req_q[i] >> 1;
        default:   target = '0;
      endcase
      grant[i]  = (target < remaining) ? target : remaining;
      remaining = remaining - grant[i];
    end
  end

  // Decreases apply at once; increases are capped at RAMP_STEP per edge.
  always_comb begin : ramp_limit
    logic [W:0] ramp_up;
    ramp_up = '0;
    total_d = '0;
    for (int i = 0; i < CH; i++) begin
      ramp_up = {1'b0, pow_q[i]} + (W+1)'(RAMP_STEP);
      if (grant[i] <= pow_q[i])
        pow_d[i] = grant[i];
      else if ({1'b0, grant[i]} < ramp_up)
        pow_d[i] = grant[i];
      else
        pow_d[i] = ramp_up[W-1:0];
      total_d = total_d + TW'(pow_d[i]);
    end
  end

  always_ff @(posedge clk) begin : stage2_reg
    if (rst) begin
      total_out <= '0;
      for (int i = 0; i < CH; i++) pow_q[i] <= '0;
    end else begin
      total_out <= total_d;
      for (int i = 0; i < CH; i++) pow_q[i] <= pow_d[i];
    end
  end

  always_comb begin : drive_outputs
    power_out   = '0;
    status_code = '0;
    for (int i = 0; i < CH; i++) begin
      power_out[i*W +: W]   = pow_q[i];
      status_code[i*2 +: 2] = state_q[i];
    end
  end

endmodule
